simmem_release_sched: RTL and testbench
=======================================

# simmem_release_sched

Per-slot release scheduler for one simulated-memory response bank. It accepts a slot identifier (internal identifier, iid) and a delay from the delay calculator. It counts the delay down, then asserts that slot's bit of the bank's multi-hot release enable until the bank reports the slot released. One instance serves the write-response bank and one serves the read-data bank. Each drives `release_en_i` and observes `released_addr_onehot_o` of its bank.

## Interface
- `Capa`, default 16: number of bank slots; equals the bank's total capacity.
- `DelayW`, default 8: width of the delay field, in cycles.
- `IidW`, default `$clog2(Capa)`: slot index width.
- `clk_i`  in  1  single clock.
- `rst_ni`  in  1  reset, asynchronous and active-low.
- `sched_valid_i`  in  1  a new schedule entry is offered.
- `sched_ready_o`  out  1  entry accepted this cycle; combinational, equals (slot `sched_iid_i` is IDLE).
- `sched_iid_i`  in  IidW  slot to schedule; the bank returned it at reservation.
- `sched_delay_i`  in  DelayW  release delay in cycles, unsigned.
- `release_en_o`  out  Capa  multi-hot; bit i is high while slot i is ELIGIBLE. Registered.
- `released_addr_onehot_i`  in  Capa  one-hot release report from the bank; zero when idle.
- `slots_busy_o`  out  IidW+1  count of non-IDLE slots. Registered.
- `err_o`  out  1  sticky protocol-error flag.
- `freeze_i`  in  1  stalls all delay counters; present only with `SIMMEM_RELEASE_SCHED_FREEZE_EN`.

## Operation
- Each slot has a state (IDLE, COUNT or ELIGIBLE) and a counter of DelayW bits.
- Handshake: an entry is accepted when `sched_valid_i && sched_ready_o` at a rising edge.
  - Valid may drop without acceptance; no stickiness is required of the producer.
  - `sched_iid_i` must be below Capa. An out-of-range iid gives `sched_ready_o` = 0 and sets `err_o` while valid.
- Acceptance into slot i:
  - delay 0: slot goes to ELIGIBLE.
  - delay d > 0: slot goes to COUNT with counter = d−1.
- COUNT state:
  - counter 0: next state is ELIGIBLE.
  - otherwise: counter decrements by 1.
  - Arithmetic is DelayW-wide with no wrap. Decrement happens only when the counter is nonzero.
- ELIGIBLE state: `release_en_o[i]` = 1. When `released_addr_onehot_i[i]` = 1, the next state is IDLE.
- Read-data bursts: the bank pulses `released_addr_onehot_i[i]` once per beat.
  - The first pulse moves the slot to IDLE.
  - Further pulses while the slot is IDLE are ignored and raise no error.
- Error: `err_o` is set by a release pulse on a slot in COUNT. The slot state is unchanged. `err_o` clears only on reset.
- Simultaneous events: acceptance and release in the same cycle are handled independently per slot.
  - They cannot target the same slot, because acceptance requires IDLE.
  - A slot released in cycle t is IDLE in t+1 and can be accepted in t+1.
- `slots_busy_o` is updated each cycle from the next-state vector, so it matches the state registers.

## Timing
- Reset, asynchronous, applied at any time including mid-count:
  - all slots IDLE, counters 0;
  - `release_en_o` = 0, `slots_busy_o` = 0, `err_o` = 0;
  - `sched_ready_o` = 1 for any in-range iid.
- Latency: an entry accepted at edge t with delay d gives `release_en_o[iid]` high from cycle t+1+d.
  - It stays high until the cycle after the release pulse is sampled.
- `sched_ready_o` is combinational from `sched_iid_i` and the state registers. There is no combinational path from `sched_valid_i` or `released_addr_onehot_i` to any output.
- Full: all Capa slots busy gives `slots_busy_o` = Capa and `sched_ready_o` = 0.

## Configuration
- `SIMMEM_RELEASE_SCHED_FREEZE_EN` defined:
  - The `freeze_i` port exists.
  - While `freeze_i` = 1, COUNT slots hold their counter and state.
  - Acceptance still loads new slots. ELIGIBLE and IDLE slots and release handling are unaffected.
  - Release latency grows by the number of frozen cycles.
- Macro undefined: no `freeze_i` port; counters always run.

## Test plan
- Reset mid-count: accept iid 3, delay 10; assert `rst_ni` low at cycle 5 -> all outputs 0 immediately; after release of reset, iid 3 is IDLE and `sched_ready_o` = 1.
- Basic latency: accept iid 2, delay 0 at edge 0 -> `release_en_o` = 0x0004 from cycle 1. Accept iid 5, delay 4 -> bit 5 rises exactly 5 cycles after acceptance. Pulse `released_addr_onehot_i` = 0x0020 -> bit 5 low next cycle and `slots_busy_o` decrements.
- Busy slot: accept iid 7, then offer iid 7 again -> `sched_ready_o` = 0 until release. Release at t, re-offer at t+1 -> accepted.
- Burst release: slot 1 ELIGIBLE; four consecutive pulses of 0x0002 -> slot IDLE after the first pulse; `err_o` stays 0.
- Full and error: fill all 16 slots with delay 255 -> `slots_busy_o` = 16 and `sched_ready_o` = 0. Pulse a release on slot 0 while it is in COUNT -> `err_o` = 1 sticky and slot 0 still counts.
- Freeze (macro on): accept iid 4, delay 6; hold `freeze_i` = 1 for 3 cycles mid-count -> bit 4 rises 10 cycles after acceptance, not 7.

Source files
------------

// File: rtl/simmem_release_sched.sv
// simmem_release_sched: per-slot release scheduler for one simulated-memory
// response bank. Each accepted slot waits out its delay, then holds its bit of
// release_en_o high until the bank reports the slot released.
//
// Optional feature: define SIMMEM_RELEASE_SCHED_FREEZE_EN to add freeze_i,
// which stalls every counting slot while high.

module simmem_release_sched #(
   parameter int unsigned Capa   = 16,
   parameter int unsigned DelayW = 8,
   parameter int unsigned IidW   = $clog2(Capa)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              sched_valid_i,
   output logic              sched_ready_o,
   input  logic [IidW-1:0]   sched_iid_i,
   input  logic [DelayW-1:0] sched_delay_i,
   output logic [Capa-1:0]   release_en_o,
   input  logic [Capa-1:0]   released_addr_onehot_i,
   output logic [IidW:0]     slots_busy_o,
`ifdef SIMMEM_RELEASE_SCHED_FREEZE_EN
   input  logic              freeze_i,
`endif
   output logic              err_o
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StCount = 2'd1;
   localparam logic [1:0] StElig  = 2'd2;

   logic [1:0]        state_q [Capa];
   logic [1:0]        state_d [Capa];
   logic [DelayW-1:0] cnt_q   [Capa];
   logic [DelayW-1:0] cnt_d   [Capa];

   logic [Capa-1:0] release_en_q, release_en_d;
   logic [IidW:0]   slots_busy_q, slots_busy_d;
   logic            err_q, err_d;

   logic [Capa-1:0] iid_sel;
   logic            iid_in_range;
   logic            accept;
   logic            freeze;

`ifdef SIMMEM_RELEASE_SCHED_FREEZE_EN
   assign freeze = freeze_i;
`else
   assign freeze = 1'b0;
`endif

   // Decode the offered iid; an out-of-range iid selects no slot at all.
   always_comb begin
      iid_sel = '0;
      for (int unsigned i = 0; i < Capa; i++) begin
         if (sched_iid_i == IidW'(i)) begin
            iid_sel[i] = 1'b1;
         end
      end
   end

   assign iid_in_range = |iid_sel;

   // Ready depends only on the offered iid and the registered slot states.
   always_comb begin
      sched_ready_o = 1'b0;
      for (int unsigned i = 0; i < Capa; i++) begin
         if (iid_sel[i] && (state_q[i] == StIdle)) begin
            sched_ready_o = 1'b1;
         end
      end
   end

   assign accept = sched_valid_i & sched_ready_o;

   // Per-slot next state: load on acceptance, count down, wait for release.
   always_comb begin
      for (int unsigned i = 0; i < Capa; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            StIdle: begin
               if (accept && iid_sel[i]) begin
                  if (sched_delay_i == '0) begin
                     state_d[i] = StElig;
                  end else begin
                     state_d[i] = StCount;
                     // Counter holds cycles left after the first one.
                     cnt_d[i]   = sched_delay_i - DelayW'(1);
                  end
               end
            end
            StCount: begin
               // A stray release pulse here is flagged below; counting goes on.
               if (!freeze) begin
                  if (cnt_q[i] == '0) begin
                     state_d[i] = StElig;
                  end else begin
                     cnt_d[i] = cnt_q[i] - DelayW'(1);
                  end
               end
            end
            StElig: begin
               if (released_addr_onehot_i[i]) begin
                  state_d[i] = StIdle;
                  cnt_d[i]   = '0;
               end
            end
            default: begin
               state_d[i] = StIdle;
               cnt_d[i]   = '0;
            end
         endcase
      end
   end

   // Registered outputs are derived from the next-state vector so they line
   // up with the state registers; the error flag is sticky until reset.
   always_comb begin
      release_en_d = '0;
      slots_busy_d = '0;
      err_d        = err_q;
      if (sched_valid_i && !iid_in_range) begin
         err_d = 1'b1;
      end
      for (int unsigned i = 0; i < Capa; i++) begin
         release_en_d[i] = (state_d[i] == StElig);
         if (state_d[i] != StIdle) begin
            slots_busy_d = slots_busy_d + (IidW+1)'(1);
         end
         if ((state_q[i] == StCount) && released_addr_onehot_i[i]) begin
            err_d = 1'b1;
         end
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < Capa; i++) begin
            state_q[i] <= StIdle;
            cnt_q[i]   <= '0;
         end
         release_en_q <= '0;
         slots_busy_q <= '0;
         err_q        <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < Capa; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         release_en_q <= release_en_d;
         slots_busy_q <= slots_busy_d;
         err_q        <= err_d;
      end
   end

   assign release_en_o = release_en_q;
   assign slots_busy_o = slots_busy_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_simmem_release_sched.sv
// Bench for simmem_release_sched: directed scenarios with literal expectations
// plus randomized traffic, all checked against a remaining-delay model.

module tb_simmem_release_sched;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        sched_valid = 1'b0;
   logic        sched_ready;
   logic [3:0]  sched_iid = '0;
   logic [7:0]  sched_delay = '0;
   logic [15:0] release_en;
   logic [15:0] released = '0;
   logic [4:0]  slots_busy;
   logic        freeze = 1'b0;
   logic        err;

   int n_tests = 0;
   int n_fail  = 0;

   simmem_release_sched #(
      .Capa   (16),
      .DelayW (8),
      .IidW   (4)
   ) dut (
      .clk_i                  (clk),
      .rst_ni                 (rst_ni),
      .sched_valid_i          (sched_valid),
      .sched_ready_o          (sched_ready),
      .sched_iid_i            (sched_iid),
      .sched_delay_i          (sched_delay),
      .release_en_o           (release_en),
      .released_addr_onehot_i (released),
      .slots_busy_o           (slots_busy),
`ifdef SIMMEM_RELEASE_SCHED_FREEZE_EN
      .freeze_i               (freeze),
`endif
      .err_o                  (err)
   );

   always #5 clk = ~clk;

   // Model: a slot is busy with some number of cycles still to wait; it is
   // eligible once nothing is left to wait.
   bit m_busy [16];
   int m_rem  [16];
   bit m_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_clear();
      for (int i = 0; i < 16; i++) begin
         m_busy[i] = 1'b0;
         m_rem[i]  = 0;
      end
      m_err = 1'b0;
   endfunction

   function automatic logic [15:0] model_en();
      logic [15:0] v = '0;
      for (int i = 0; i < 16; i++) v[i] = m_busy[i] && (m_rem[i] == 0);
      return v;
   endfunction

   function automatic int model_count();
      int c = 0;
      for (int i = 0; i < 16; i++) if (m_busy[i]) c++;
      return c;
   endfunction

   function automatic void model_step();
      bit n_busy [16];
      int n_rem  [16];
      bit ready;
      for (int i = 0; i < 16; i++) begin
         n_busy[i] = m_busy[i];
         n_rem[i]  = m_rem[i];
         if (released[i]) begin
            if (m_busy[i] && m_rem[i] == 0) n_busy[i] = 1'b0;
            else if (m_busy[i]) m_err = 1'b1;
         end
         if (m_busy[i] && m_rem[i] > 0 && !freeze) n_rem[i] = m_rem[i] - 1;
      end
      ready = !m_busy[sched_iid];
      if (sched_valid && ready) begin
         n_busy[sched_iid] = 1'b1;
         n_rem[sched_iid]  = int'(sched_delay);
      end
      for (int i = 0; i < 16; i++) begin
         m_busy[i] = n_busy[i];
         m_rem[i]  = n_rem[i];
      end
   endfunction

   // Compare process: advance the model on each rising edge, compare mid-cycle.
   initial begin
      model_clear();
      forever begin
         @(posedge clk);
         if (!rst_ni) model_clear();
         else model_step();
         @(negedge clk);
         #2;
         if (!rst_ni) model_clear();
         check("mon_release_en", 32'(release_en), 32'(model_en()));
         check("mon_slots_busy", 32'(slots_busy), 32'(model_count()));
         check("mon_err", 32'(err), 32'(m_err));
         check("mon_ready", 32'(sched_ready), 32'(!m_busy[sched_iid]));
      end
   end

   // Stimulus with hand-computed expectations.
   initial begin
      int cand [$];
      int r;

      // Reset mid-count.
      @(negedge clk);
      rst_ni = 1'b1;
      sched_valid = 1'b1; sched_iid = 4'd3; sched_delay = 8'd10;
      @(negedge clk);
      sched_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst_ni = 1'b0;
      #1;
      check("rst_release_en", 32'(release_en), 32'h0);
      check("rst_slots_busy", 32'(slots_busy), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      @(negedge clk);
      rst_ni = 1'b1; sched_iid = 4'd3;
      #1;
      check("rst_ready_iid3", 32'(sched_ready), 32'h1);

      // Basic latency.
      @(negedge clk);
      sched_valid = 1'b1; sched_iid = 4'd2; sched_delay = 8'd0;
      @(negedge clk);
      #1;
      check("lat_d0_en", 32'(release_en), 32'h0004);
      sched_iid = 4'd5; sched_delay = 8'd4;
      @(negedge clk);
      sched_valid = 1'b0;
      #1;
      check("lat_d4_k0", 32'(release_en[5]), 32'h0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         #1;
         check("lat_d4_step", 32'(release_en[5]), 32'((k == 4) ? 1 : 0));
      end
      check("lat_busy_two", 32'(slots_busy), 32'd2);
      released = 16'h0020;
      @(negedge clk);
      released = '0;
      #1;
      check("lat_rel5_en", 32'(release_en), 32'h0004);
      check("lat_rel5_busy", 32'(slots_busy), 32'd1);
      released = 16'h0004;
      @(negedge clk);
      released = '0;

      // Busy slot and re-offer right after release.
      sched_valid = 1'b1; sched_iid = 4'd7; sched_delay = 8'd0;
      @(negedge clk);
      #1;
      check("busy_ready0_a", 32'(sched_ready), 32'h0);
      @(negedge clk);
      released = 16'h0080;
      #1;
      check("busy_ready0_b", 32'(sched_ready), 32'h0);
      @(negedge clk);
      released = '0;
      #1;
      check("reoffer_ready", 32'(sched_ready), 32'h1);
      @(negedge clk);
      sched_valid = 1'b0;
      #1;
      check("reoffer_en", 32'(release_en), 32'h0080);
      released = 16'h0080;
      @(negedge clk);
      released = '0;
      #1;
      check("reoffer_idle", 32'(slots_busy), 32'd0);

      // Burst release.
      sched_valid = 1'b1; sched_iid = 4'd1; sched_delay = 8'd0;
      @(negedge clk);
      sched_valid = 1'b0;
      #1;
      check("burst_en", 32'(release_en), 32'h0002);
      for (int k = 0; k < 4; k++) begin
         released = 16'h0002;
         @(negedge clk);
         #1;
         check("burst_idle", 32'(release_en), 32'h0);
         check("burst_err", 32'(err), 32'h0);
      end
      released = '0;

      // Full and error.
      for (int i = 0; i < 16; i++) begin
         sched_valid = 1'b1; sched_iid = 4'(i); sched_delay = 8'd255;
         @(negedge clk);
      end
      sched_valid = 1'b0;
      #1;
      check("full_busy", 32'(slots_busy), 32'd16);
      check("full_ready", 32'(sched_ready), 32'h0);
      released = 16'h0001;
      @(negedge clk);
      released = '0; sched_iid = 4'd0;
      #1;
      check("count_rel_err", 32'(err), 32'h1);
      check("count_rel_busy", 32'(slots_busy), 32'd16);
      repeat (238) @(negedge clk);
      #1;
      check("slot0_not_yet", 32'(release_en), 32'h0);
      check("err_sticky", 32'(err), 32'h1);
      @(negedge clk);
      #1;
      check("slot0_elig", 32'(release_en), 32'h0001);
      @(negedge clk);
      rst_ni = 1'b0;
      #1;
      check("rst_err_clear", 32'(err), 32'h0);
      @(negedge clk);
      rst_ni = 1'b1;

`ifdef SIMMEM_RELEASE_SCHED_FREEZE_EN
      // Freeze: three stalled cycles push the rise from 7 to 10 cycles.
      sched_valid = 1'b1; sched_iid = 4'd4; sched_delay = 8'd6;
      @(negedge clk);
      sched_valid = 1'b0;
      @(negedge clk);
      freeze = 1'b1;
      repeat (3) @(negedge clk);
      freeze = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      check("freeze_not_yet", 32'(release_en[4]), 32'h0);
      @(negedge clk);
      #1;
      check("freeze_elig", 32'(release_en[4]), 32'h1);
      released = 16'h0010;
      @(negedge clk);
      released = '0;
`endif

      // Randomized traffic.
      for (int c = 0; c < 2500; c++) begin
         @(negedge clk);
         if (!rst_ni) begin
            rst_ni = 1'b1;
         end else if ($urandom_range(299) == 0) begin
            rst_ni = 1'b0;
         end
         sched_valid = 1'($urandom_range(1));
         sched_iid   = 4'($urandom_range(15));
         sched_delay = ($urandom_range(3) == 0) ? 8'($urandom_range(40)) : 8'($urandom_range(5));
`ifdef SIMMEM_RELEASE_SCHED_FREEZE_EN
         freeze = ($urandom_range(3) == 0);
`endif
         cand.delete();
         for (int i = 0; i < 16; i++) if (m_busy[i] && m_rem[i] == 0) cand.push_back(i);
         r = int'($urandom_range(39));
         if (r == 0) released = 16'd1 << $urandom_range(15);
         else if (r < 20 && cand.size() > 0) released = 16'd1 << cand[$urandom_range(cand.size() - 1)];
         else released = '0;
      end
      @(negedge clk);
      sched_valid = 1'b0; released = '0; freeze = 1'b0; rst_ni = 1'b1;
      repeat (3) @(negedge clk);
      #3;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
